uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Receive-side deframer for the UART core. It synchronizes the serial `Rx` line, or the transmitter loopback line during BIST, and assembles one frame per bit period of `Clk`: a start bit, data MSB first, optional even parity, and stop bits. It checks break, parity and framing, then hands each word either to the receive FIFO or to the BIST comparator. It also drives `RTS` from the FIFO's full flag.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `PARITY_BIT`, 1: 1 = one even-parity bit follows the data; 0 = no parity bit.
- `STOP_BITS`, 2: number of stop bits (≥1).

- `Clk` in 1: baud-rate clock, one bit period per cycle, posedge active.
- `Rst` in 1: asynchronous, active-high reset.
- `Rx` in 1: external serial input; idles high.
- `Loop_In` in 1: transmitter serial output, used as the source when in BIST.
- `BIST_Mode` in 1: selects `Loop_In` as the source and `BIST_Valid` as the strobe.
- `FIFO_Full` in 1: full flag from the receive FIFO.
- `Rx_Data` out DATA_BITS: last received word.
- `Rx_Valid` out 1: one-cycle FIFO write strobe.
- `BIST_Valid` out 1: one-cycle strobe to the BIST comparator.
- `Rx_Error` out 3: bit 0 = break, bit 1 = parity, bit 2 = frame.
- `Rx_Busy` out 1: high while a frame is in progress.
- `RTS` out 1: ready-to-send to the far end.

## Operation
- **Reset.** While `Rst` is high:
  - FSM goes to IDLE; synchronizer flops load 1.
  - `Rx_Data`=0, `Rx_Valid`=0, `BIST_Valid`=0, `Rx_Error`=000, `Rx_Busy`=0, `RTS`=0.
  - Reset mid-frame discards the partial frame and emits no strobe.
- **Source and synchronization.**
  - Source = `BIST_Mode ? Loop_In : Rx`, passed through a 2-flop synchronizer; its output is `Rx_s`.
  - `BIST_Mode` is latched when the FSM leaves IDLE and held for the whole frame.
- **FSM states.**
  - IDLE: `Rx_s`=0 → DATA, bit count = DATA_BITS-1. This cycle consumes the start bit.
  - DATA: shift `Rx_s` into the LSB of the shift register (so the MSB arrives first) and XOR it into running parity. At count 0 → PARITY if `PARITY_BIT`, else STOP.
  - PARITY: record parity error = `Rx_s` XOR running parity → STOP.
  - STOP: consume STOP_BITS cycles. Any stop bit at 0 sets the frame-error candidate. On the last stop bit, complete the frame.
    - Break: start, data, parity and stop bits all 0 → BREAK_WAIT.
    - Otherwise → IDLE.
  - BREAK_WAIT: stay until `Rx_s`=1, then → IDLE. A low line is never re-read as a new start bit.
- **Completion**, registered on the edge that consumes the last stop bit:
  - Normal frame:
    - `Rx_Data` ← shift register.
    - `Rx_Error` ← {frame, parity, 0}.
    - Pulse `Rx_Valid` (or `BIST_Valid` if latched BIST) for 1 cycle.
    - Parity- and frame-errored words are still strobed.
  - Break:
    - `Rx_Error` ← 001; parity and frame bits are suppressed.
    - `Rx_Data` is unchanged; no strobe.
  - `Rx_Error` holds until the next completion or reset.
- **Busy and flow control.**
  - `Rx_Busy` = state ≠ IDLE, registered.
  - `RTS` ← ~`FIFO_Full` each edge (registered). Frames already in progress complete regardless of `RTS`.
  - Overflow accounting belongs to the FIFO.

## Timing
- Pin-to-FSM latency is 2 edges. If the pin's last stop bit is first captured at edge A, then the completion outputs update at edge A+2.
- Frame occupancy is 1+DATA_BITS+PARITY_BIT+STOP_BITS cycles. A start bit may be consumed on the cycle immediately after completion (back-to-back frames, no idle gap).
- `RTS` follows `FIFO_Full` with 1 cycle of latency.
- Strobes are exactly 1 cycle and are never asserted together.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, DATA, PARITY, STOP, BREAK_WAIT);
  - error index constants `ERR_BREAK`=0, `ERR_PARITY`=1, `ERR_FRAME`=2.
  - The transmitter and BIST reuse these.
- One sub-module, `uart_sync2`: the 2-flop synchronizer with its reset value as a parameter.
- Bit counter width is $clog2(max(DATA_BITS,STOP_BITS)).

## Test plan
Defaults apply: 8 data bits, parity, 2 stop bits.
- **Clean frame.** Send 8'hA5 with pin sequence 0,1,0,1,0,0,1,0,1,0,1,1 (parity = 0). Expect `Rx_Data`=A5, a 1-cycle `Rx_Valid` at A+2, `Rx_Error`=000.
- **Parity error.** Send 8'hAA with the parity bit inverted to 1. Expect `Rx_Error`=010, `Rx_Valid` pulses, `Rx_Data`=AA.
- **Framing error.** Send 8'hAA with both stop bits 0. Expect `Rx_Error`=100 and `Rx_Valid` pulses.
- **Break, then recovery.**
  - Hold the pin low for 12 bits, then 3 more low cycles, then high. Expect `Rx_Error`=001, no strobe, `Rx_Busy` high until the line is seen high.
  - Then send 8'h3C. Expect `Rx_Data`=3C, `Rx_Error`=000.
- **Flow control and BIST routing.**
  - Raise `FIFO_Full`: `RTS`=0 on the next edge. Drop it: `RTS`=1 one edge later.
  - With `BIST_Mode`=1, send 8'h5A on `Loop_In`. Expect `BIST_Valid` pulses and `Rx_Valid` stays 0.
- **Reset mid-frame.** Assert `Rst` during data bit 4. All outputs clear immediately and no strobe occurs. A following frame 8'h01 is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and error-vector bit positions.
// The transmitter and BIST blocks import the same names.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } uart_state_e;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] err_vec(input logic brk, input logic par, input logic frm);
    logic [2:0] e;
    e             = '0;
    e[ERR_BREAK]  = brk;
    e[ERR_PARITY] = par;
    e[ERR_FRAME]  = frm;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Serial inputs and word/status outputs of the UART receive deframer.
// slave is the deframer side; master is the driver/monitor side.
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);
  logic                 Rx;
  logic                 Loop_In;
  logic                 BIST_Mode;
  logic                 FIFO_Full;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Rx_Valid;
  logic                 BIST_Valid;
  logic [2:0]           Rx_Error;
  logic                 Rx_Busy;
  logic                 RTS;

  modport slave (
    input  Rx, Loop_In, BIST_Mode, FIFO_Full,
    output Rx_Data, Rx_Valid, BIST_Valid, Rx_Error, Rx_Busy, RTS
  );

  modport master (
    output Rx, Loop_In, BIST_Mode, FIFO_Full,
    input  Rx_Data, Rx_Valid, BIST_Valid, Rx_Error, Rx_Busy, RTS
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; both flops load RESET_VAL so the output starts
// at the line's idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: one bit per clock, MSB-first data, optional even
// parity, break/parity/frame checks, strobes to the FIFO or BIST comparator.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_BIT = 1,
  parameter int STOP_BITS  = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  uart_rx_deframer_if.slave  bus
);
  localparam int MAX_BITS = max_int(DATA_BITS, STOP_BITS);
  localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_q;
  logic                 par_err_q;
  logic                 frame_q;
  logic                 any_one_q;
  logic                 bist_q;
  logic                 rx_valid_q;
  logic                 bist_valid_q;
  logic                 busy_q;
  logic                 rts_q;
  logic [2:0]           err_q;
  logic                 src_sel;
  logic                 src;
  logic                 rx_s;

  // Mid-frame the source stays on the mode latched at the start bit.
  assign src_sel = (state_q == IDLE) ? bus.BIST_Mode : bist_q;
  assign src     = src_sel ? bus.Loop_In : bus.Rx;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (Clk),
    .rst_i (Rst),
    .d_i   (src),
    .q_o   (rx_s)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      par_q        <= 1'b0;
      par_err_q    <= 1'b0;
      frame_q      <= 1'b0;
      any_one_q    <= 1'b0;
      bist_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      bist_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      rts_q        <= 1'b0;
      err_q        <= '0;
    end else begin
      rx_valid_q   <= 1'b0;
      bist_valid_q <= 1'b0;
      rts_q        <= ~bus.FIFO_Full;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q   <= DATA;
            busy_q    <= 1'b1;
            cnt_q     <= CNT_W'(DATA_BITS - 1);
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
            frame_q   <= 1'b0;
            any_one_q <= 1'b0;
            bist_q    <= bus.BIST_Mode;
          end
        end
        DATA: begin
          shreg_q   <= (shreg_q << 1) | DATA_BITS'(rx_s);
          par_q     <= par_q ^ rx_s;
          any_one_q <= any_one_q | rx_s;
          if (cnt_q == '0) begin
            if (PARITY_BIT != 0) begin
              state_q <= PARITY;
            end else begin
              state_q <= STOP;
              cnt_q   <= CNT_W'(STOP_BITS - 1);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PARITY: begin
          par_err_q <= rx_s ^ par_q;
          any_one_q <= any_one_q | rx_s;
          state_q   <= STOP;
          cnt_q     <= CNT_W'(STOP_BITS - 1);
        end
        STOP: begin
          if (!rx_s) frame_q <= 1'b1;
          any_one_q <= any_one_q | rx_s;
          if (cnt_q == '0) begin
            // An all-zero frame is a break: error only, data and strobes untouched.
            if (!any_one_q && !rx_s) begin
              state_q <= BREAK_WAIT;
              err_q   <= err_vec(1'b1, 1'b0, 1'b0);
            end else begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              data_q       <= shreg_q;
              err_q        <= err_vec(1'b0, par_err_q, frame_q | ~rx_s);
              rx_valid_q   <= ~bist_q;
              bist_valid_q <= bist_q;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BREAK_WAIT: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Rx_Data    = data_q;
  assign bus.Rx_Valid   = rx_valid_q;
  assign bus.BIST_Valid = bist_valid_q;
  assign bus.Rx_Error   = err_q;
  assign bus.Rx_Busy    = busy_q;
  assign bus.RTS        = rts_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: reset, flow control, a table of single frames,
// break recovery, reset mid-frame, and random back-to-back frames vs a model.
module tb_uart_rx_deframer;
  logic Clk;
  logic Rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   route     = 0;  // 0: pin on Rx, 1: pin on Loop_In, 2: both
  logic [7:0] last_data;

  uart_rx_deframer_if #(.DATA_BITS(8)) bus ();

  uart_rx_deframer #(.DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic [1:0] stops;
    logic       bist;
    logic       exp_rxv;
    logic       exp_bv;
    logic [7:0] exp_data;
    logic [2:0] exp_err;
  } vec_t;

  typedef struct {
    int         step;
    logic       bist;
    logic [7:0] data;
    logic [2:0] err;
  } ev_t;

  vec_t vecs[7];
  logic rq_pin[$];
  logic rq_mode[$];
  ev_t  evq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Drive one bit period; the next posedge captures it, outputs sampled 1 unit later.
  task automatic step(input logic pin);
    case (route)
      0:       begin bus.Rx = pin;  bus.Loop_In = 1'b1; end
      1:       begin bus.Rx = 1'b1; bus.Loop_In = pin;  end
      default: begin bus.Rx = pin;  bus.Loop_In = pin;  end
    endcase
    @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pf, input logic [1:0] st);
    step(1'b0);
    for (int i = 7; i >= 0; i--) step(d[i]);
    step((^d) ^ pf);
    step(st[1]);
    step(st[0]);
  endtask

  task automatic send_check(input string nm, input vec_t v);
    send_frame(v.data, v.pflip, v.stops);
    chk({nm, " busy"}, bus.Rx_Busy, 1);
    step(1'b1);
    chk({nm, " early rxv"}, bus.Rx_Valid, 0);
    chk({nm, " early bv"}, bus.BIST_Valid, 0);
    step(1'b1);
    chk({nm, " rxv"}, bus.Rx_Valid, v.exp_rxv);
    chk({nm, " bv"}, bus.BIST_Valid, v.exp_bv);
    chk({nm, " data"}, bus.Rx_Data, v.exp_data);
    chk({nm, " err"}, bus.Rx_Error, v.exp_err);
    chk({nm, " idle"}, bus.Rx_Busy, 0);
    step(1'b1);
    chk({nm, " rxv end"}, bus.Rx_Valid, 0);
    chk({nm, " bv end"}, bus.BIST_Valid, 0);
    chk({nm, " err hold"}, bus.Rx_Error, v.exp_err);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{8'hA5, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'hA5, 3'b000};
    vecs[1] = '{8'hAA, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 8'hAA, 3'b010};
    vecs[2] = '{8'hAA, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'hAA, 3'b100};
    vecs[3] = '{8'h00, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000};
    vecs[4] = '{8'h00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 3'b100};
    vecs[5] = '{8'hFF, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'hFF, 3'b110};
    vecs[6] = '{8'h5A, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 8'h5A, 3'b000};

    Rst = 1'b1;
    bus.Rx = 1'b1;
    bus.Loop_In = 1'b1;
    bus.BIST_Mode = 1'b0;
    bus.FIFO_Full = 1'b0;
    #22;
    chk("reset data", bus.Rx_Data, 0);
    chk("reset err", bus.Rx_Error, 0);
    chk("reset rxv", bus.Rx_Valid, 0);
    chk("reset bv", bus.BIST_Valid, 0);
    chk("reset busy", bus.Rx_Busy, 0);
    chk("reset rts", bus.RTS, 0);
    @(negedge Clk);
    Rst = 1'b0;

    step(1'b1);
    chk("rts up", bus.RTS, 1);
    bus.FIFO_Full = 1'b1;
    step(1'b1);
    chk("rts full", bus.RTS, 0);
    bus.FIFO_Full = 1'b0;
    step(1'b1);
    chk("rts free", bus.RTS, 1);

    foreach (vecs[k]) begin
      route = vecs[k].bist ? 1 : 0;
      bus.BIST_Mode = vecs[k].bist;
      send_check($sformatf("vec%0d", k), vecs[k]);
      last_data = vecs[k].exp_data;
    end
    route = 0;
    bus.BIST_Mode = 1'b0;
    repeat (2) step(1'b1);

    // Break: 15 low bit periods, then high.
    for (int k = 1; k <= 15; k++) begin
      step(1'b0);
      chk("break rxv", bus.Rx_Valid, 0);
      chk("break bv", bus.BIST_Valid, 0);
      if (k == 14) begin
        chk("break err", bus.Rx_Error, 3'b001);
        chk("break data", bus.Rx_Data, last_data);
      end
      if (k >= 3) chk("break busy", bus.Rx_Busy, 1);
    end
    step(1'b1);
    chk("break wait1", bus.Rx_Busy, 1);
    step(1'b1);
    chk("break wait2", bus.Rx_Busy, 1);
    step(1'b1);
    chk("break done", bus.Rx_Busy, 0);
    chk("break err hold", bus.Rx_Error, 3'b001);

    bus.FIFO_Full = 1'b1;
    v = '{8'h3C, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'h3C, 3'b000};
    send_check("recover", v);
    chk("rts during frame", bus.RTS, 0);
    bus.FIFO_Full = 1'b0;
    step(1'b1);

    // Reset during data bit 4.
    step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    chk("pre-reset busy", bus.Rx_Busy, 1);
    #2 Rst = 1'b1;
    bus.Rx = 1'b1;
    #1;
    chk("midrst data", bus.Rx_Data, 0);
    chk("midrst err", bus.Rx_Error, 0);
    chk("midrst busy", bus.Rx_Busy, 0);
    chk("midrst rts", bus.RTS, 0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step(1'b1);
      chk("post-rst rxv", bus.Rx_Valid, 0);
    end
    v = '{8'h01, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 8'h01, 3'b000};
    send_check("after reset", v);

    // Random frames, mixed routing, gaps of 0..2 idle bits.
    for (int f = 0; f < 40; f++) begin
      int gap, s;
      logic [7:0] d;
      logic pf, bm;
      logic [1:0] st;
      logic bits[12];
      gap = $urandom_range(0, 2);
      repeat (gap) begin rq_pin.push_back(1'b1); rq_mode.push_back(1'b0); end
      s  = rq_pin.size();
      d  = 8'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      if (d == 8'h00 && !pf && st == 2'b00) st = 2'b10;
      bm = 1'($urandom_range(0, 1));
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = d[7 - i];
      bits[9]  = (^d) ^ pf;
      bits[10] = st[1];
      bits[11] = st[0];
      foreach (bits[i]) begin rq_pin.push_back(bits[i]); rq_mode.push_back(bm); end
      evq.push_back('{s + 13, bm, d, {(st != 2'b11), pf, 1'b0}});
    end
    route = 2;
    for (int i = 0; i < rq_pin.size() + 4; i++) begin
      bus.BIST_Mode = (i < rq_pin.size()) ? rq_mode[i] : 1'b0;
      step((i < rq_pin.size()) ? rq_pin[i] : 1'b1);
      if (evq.size() > 0 && evq[0].step == i) begin
        chk($sformatf("rnd rxv @%0d", i), bus.Rx_Valid, !evq[0].bist);
        chk($sformatf("rnd bv @%0d", i), bus.BIST_Valid, evq[0].bist);
        chk($sformatf("rnd data @%0d", i), bus.Rx_Data, evq[0].data);
        chk($sformatf("rnd err @%0d", i), bus.Rx_Error, evq[0].err);
        void'(evq.pop_front());
      end else begin
        chk($sformatf("rnd quiet rxv @%0d", i), bus.Rx_Valid, 0);
        chk($sformatf("rnd quiet bv @%0d", i), bus.BIST_Valid, 0);
      end
    end
    chk("rnd all events seen", evq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
